// File: rtl/snax_simbacore_out_packer.sv
// Packs PackFactor narrow accelerator beats into one wide streamer word with per-lane strobes.
// A flush pulse emits a trailing partial word at the end of a layer.
module snax_simbacore_out_packer #(
  parameter int unsigned InWidth    = 64,
  parameter int unsigned PackFactor = 4,
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned OutWidth   = InWidth * PackFactor,
  parameter int unsigned IdxWidth   = $clog2(PackFactor + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [InWidth-1:0]    in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [OutWidth-1:0]   out_data_o,
  output logic [PackFactor-1:0] out_strb_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  input  logic                  flush_i,
  output logic [CntWidth-1:0]   word_cnt_o,
  output logic                  busy_o
);

  localparam int unsigned LaneBits = (PackFactor - 1) * InWidth;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(PackFactor - 1);

  // Only PackFactor-1 lanes are stored; the last beat goes straight into the output register.
  logic [LaneBits-1:0]   lanes_q, lanes_d;
  logic [IdxWidth-1:0]   cnt_q, cnt_d;
  logic [OutWidth-1:0]   out_data_q, out_data_d;
  logic [PackFactor-1:0] out_strb_q, out_strb_d;
  logic                  out_valid_q, out_valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [CntWidth-1:0]   word_cnt_q, word_cnt_d;

  logic out_free, in_ready, in_fire, out_fire;

  assign out_free = !out_valid_q || out_ready_i;
  assign in_ready = !flush_pend_q && ((cnt_q < LastIdx) || out_free);
  assign in_fire  = in_valid_i && in_ready;
  assign out_fire = out_valid_q && out_ready_i;

  always_comb begin
    lanes_d      = lanes_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;
    word_cnt_d   = word_cnt_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      word_cnt_d  = word_cnt_q + CntWidth'(1);
    end

    if (flush_pend_q) begin
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        // Stale data in lanes above cnt_q must not leak into the partial word.
        out_data_d = '0;
        out_strb_d = '0;
        for (int unsigned k = 0; k < PackFactor - 1; k++) begin
          if (IdxWidth'(k) < cnt_q) begin
            out_data_d[k*InWidth +: InWidth] = lanes_q[k*InWidth +: InWidth];
            out_strb_d[k]                    = 1'b1;
          end
        end
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end
    end else if (in_fire) begin
      if (cnt_q < LastIdx) begin
        for (int unsigned k = 0; k < PackFactor - 1; k++) begin
          if (cnt_q == IdxWidth'(k)) lanes_d[k*InWidth +: InWidth] = in_data_i;
        end
        cnt_d = cnt_q + IdxWidth'(1);
      end else begin
        out_data_d  = {in_data_i, lanes_q};
        out_strb_d  = '1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end

    if (flush_i && !flush_pend_q) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lanes_q      <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      lanes_q      <= lanes_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_valid_o = out_valid_q;
  assign word_cnt_o  = word_cnt_q;
  assign busy_o      = (cnt_q != '0) || out_valid_q || flush_pend_q;

endmodule
